// File: rtl/dma_ci_memory_pkg.sv
// Shared constants and types for the DMA custom-instruction scratch memory.
package dma_ci_memory_pkg;

  localparam logic [2:0] CI_FUNC_MEM = 3'd0;
  localparam int unsigned RAM_DEPTH  = 512;
  localparam int unsigned RAM_AW     = 9;
  localparam int unsigned DATA_W     = 32;

  // A CI read answers one cycle after its start; a CI write answers at once.
  typedef enum logic {
    CI_IDLE,
    CI_READ_DONE
  } ci_state_t;

endpackage

// File: rtl/counter.sv
// Generic enabled up/down counter with modular wrap-around.
module counter #(
  parameter int unsigned bitWidth = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                direction,
  output logic [bitWidth-1:0] counterValue
);

  logic [bitWidth-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      if (direction) begin
        count <= count + bitWidth'(1);
      end else begin
        count <= count - bitWidth'(1);
      end
    end
  end

  assign counterValue = count;

endmodule

// File: rtl/dma_ram_512x32.sv
// 512x32 single-port RAM: one write port and a registered read that returns old data on collision.
module dma_ram_512x32
  import dma_ci_memory_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] rdreg;

  // Contents are deliberately not reset; only the output register is.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdreg <= '0;
    end else begin
      rdreg <= mem[addr];
    end
  end

  assign rdata = rdreg;

endmodule

// File: rtl/ramDmaCi.sv
// CI-accessible scratch RAM; DMA streams through valueA/valueB without needing a start strobe.
module ramDmaCi
  import dma_ci_memory_pkg::*;
#(
  parameter logic [7:0] customId = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic [31:0] result,
  output logic        done
);

  ci_state_t state, state_next;
  logic      selected;
  logic      mem_we;
  logic      unused_value_a_high;

  assign selected            = (ciN == customId) && (valueA[12:10] == CI_FUNC_MEM);
  assign mem_we              = selected && valueA[9];
  assign unused_value_a_high = ^valueA[31:13];

  dma_ram_512x32 u_ram (
    .clock (clock),
    .reset (reset),
    .we    (mem_we),
    .addr  (valueA[RAM_AW-1:0]),
    .wdata (valueB),
    .rdata (result)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CI_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new start may overlap the done of a previous read, so both feed done.
  always_comb begin
    state_next = CI_IDLE;
    done       = (state == CI_READ_DONE);
    if (start && selected) begin
      if (valueA[9]) begin
        done = 1'b1;
      end else begin
        state_next = CI_READ_DONE;
      end
    end
  end

endmodule

// File: rtl/dma_ci_memory.sv
// DMA CI memory slice: scratch RAM with CI handshake plus the block/burst counter.
module dma_ci_memory #(
  parameter logic [7:0]  customId = 8'h00,
  parameter int unsigned bitWidth = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          ciN,
  input  logic [31:0]         valueA,
  input  logic [31:0]         valueB,
  output logic [31:0]         result,
  output logic                done,
  input  logic                enable,
  input  logic                direction,
  output logic [bitWidth-1:0] counterValue
);

  ramDmaCi #(
    .customId (customId)
  ) u_ram_ci (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .ciN    (ciN),
    .valueA (valueA),
    .valueB (valueB),
    .result (result),
    .done   (done)
  );

  counter #(
    .bitWidth (bitWidth)
  ) u_counter (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .direction    (direction),
    .counterValue (counterValue)
  );

endmodule

// File: tb/tb_dma_ci_memory.sv
// Directed bench for dma_ci_memory: CI handshake, streaming RAM access and counter.
module tb_dma_ci_memory;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic [31:0] result;
  logic        done;
  logic        enable;
  logic        direction;
  logic [7:0]  counterValue;

  int unsigned vectors;
  int unsigned miscompares;

  dma_ci_memory #(
    .customId (8'h00),
    .bitWidth (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .ciN          (ciN),
    .valueA       (valueA),
    .valueB       (valueB),
    .result       (result),
    .done         (done),
    .enable       (enable),
    .direction    (direction),
    .counterValue (counterValue)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs();
    start  = 1'b0;
    ciN    = 8'h00;
    valueA = '0;
    valueB = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    enable    = 1'b0;
    direction = 1'b1;
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if (counterValue !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_counter: got %0d expected 0", counterValue);
    end
    vectors++;
    if (result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_result: got %h expected 00000000", result);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    reset = 1'b0;
  endtask

  task automatic test_ci_write_read();
    @(negedge clock);
    start  = 1'b1;
    ciN    = 8'h00;
    valueA = 32'h205;
    valueB = 32'hDEADBEEF;
    #1;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL ci_write_done: got %b expected 1", done);
    end
    @(negedge clock);
    valueA = 32'h005;
    valueB = 32'h0;
    #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL ci_read_issue_done: got %b expected 0", done);
    end
    @(negedge clock);
    idle_inputs();
    valueA = 32'h005;
    #1;
    vectors++;
    if (done !== 1'b1 || result !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL ci_read_data: got done=%b result=%h expected done=1 result=deadbeef", done, result);
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL ci_read_done_one_cycle: got %b expected 0", done);
    end
  endtask

  task automatic test_deselect();
    @(negedge clock);
    start  = 1'b1;
    ciN    = 8'h00;
    valueA = 32'h207;
    valueB = 32'h11111111;
    @(negedge clock);
    ciN    = 8'h01;
    valueB = 32'h00000BAD;
    #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL deselect_ciN_done: got %b expected 0", done);
    end
    @(negedge clock);
    ciN    = 8'h00;
    valueA = 32'h607;
    valueB = 32'h00000BAD;
    #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL deselect_func_done: got %b expected 0", done);
    end
    @(negedge clock);
    idle_inputs();
    valueA = 32'h007;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL deselect_late_done: got %b expected 0", done);
    end
    @(negedge clock);
    vectors++;
    if (result !== 32'h11111111) begin
      miscompares++;
      $display("FAIL deselect_mem7: got %h expected 11111111", result);
    end
  endtask

  task automatic test_streaming();
    for (int a = 0; a < 16; a++) begin
      @(negedge clock);
      start  = 1'b0;
      ciN    = 8'h00;
      valueA = 32'h200 | 32'(a);
      valueB = 32'(a * 3);
    end
    // Upper valueA bits must not affect addressing.
    for (int a = 0; a < 16; a++) begin
      @(negedge clock);
      valueA = 32'hFFFF_E000 | 32'(a);
      valueB = 32'h0;
      @(negedge clock);
      vectors++;
      if (result !== 32'(a * 3) || done !== 1'b0) begin
        miscompares++;
        $display("FAIL stream_read[%0d]: got result=%h done=%b expected result=%h done=0",
                 a, result, done, 32'(a * 3));
      end
    end
    @(negedge clock);
    valueA = 32'h203;
    valueB = 32'h99;
    @(negedge clock);
    valueA = 32'h003;
    valueB = 32'h0;
    vectors++;
    if (result !== 32'd9) begin
      miscompares++;
      $display("FAIL read_before_write_old: got %h expected 00000009", result);
    end
    @(negedge clock);
    vectors++;
    if (result !== 32'h99) begin
      miscompares++;
      $display("FAIL read_before_write_new: got %h expected 00000099", result);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    start  = 1'b1;
    ciN    = 8'h00;
    valueA = 32'h001;
    @(negedge clock);
    valueA = 32'h002;
    #1;
    vectors++;
    if (done !== 1'b1 || result !== 32'd3) begin
      miscompares++;
      $display("FAIL b2b_first: got done=%b result=%h expected done=1 result=00000003", done, result);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    vectors++;
    if (done !== 1'b1 || result !== 32'd6) begin
      miscompares++;
      $display("FAIL b2b_second: got done=%b result=%h expected done=1 result=00000006", done, result);
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: got %b expected 0", done);
    end
  endtask

  task automatic test_counter();
    @(negedge clock);
    enable    = 1'b1;
    direction = 1'b1;
    repeat (300) @(negedge clock);
    enable = 1'b0;
    vectors++;
    if (counterValue !== 8'd44) begin
      miscompares++;
      $display("FAIL counter_up300: got %0d expected 44", counterValue);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++;
    if (counterValue !== 8'd0) begin
      miscompares++;
      $display("FAIL counter_reset: got %0d expected 0", counterValue);
    end
    enable    = 1'b1;
    direction = 1'b0;
    @(negedge clock);
    enable = 1'b0;
    vectors++;
    if (counterValue !== 8'd255) begin
      miscompares++;
      $display("FAIL counter_down_wrap: got %0d expected 255", counterValue);
    end
    repeat (3) @(negedge clock);
    vectors++;
    if (counterValue !== 8'd255) begin
      miscompares++;
      $display("FAIL counter_hold: got %0d expected 255", counterValue);
    end
  endtask

  task automatic test_reset_collision();
    @(negedge clock);
    enable    = 1'b1;
    direction = 1'b0;
    reset     = 1'b1;
    @(negedge clock);
    reset  = 1'b0;
    enable = 1'b0;
    vectors++;
    if (counterValue !== 8'd0) begin
      miscompares++;
      $display("FAIL counter_reset_enable: got %0d expected 0", counterValue);
    end
    start  = 1'b1;
    ciN    = 8'h00;
    valueA = 32'h005;
    reset  = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    #1;
    vectors++;
    if (done !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_cancels_read: got done=%b result=%h expected done=0 result=00000000", done, result);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_ci_write_read();
    test_deselect();
    test_streaming();
    test_back_to_back();
    test_counter();
    test_reset_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
